// File: rtl/darkbus_pkg.sv
// ============================================================================
// darkbus_pkg : shared types and widths for the darkbus arbiter slice
// Revision    : 1.0
// ============================================================================
`default_nettype none

package darkbus_pkg;

    localparam int DARKBUS_AW = 32;
    localparam int DARKBUS_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    function automatic arb_port_t other_port(input arb_port_t p);
        return (p == PORT_I) ? PORT_D : PORT_I;
    endfunction

endpackage

`default_nettype wire

// File: rtl/darkbus_arb_pick.sv
// ============================================================================
// darkbus_arb_pick : combinational winner selection between fetch and data
// Revision         : 1.0
// ============================================================================
`default_nettype none

module darkbus_arb_pick
    import darkbus_pkg::*;
#(
    parameter int DATA_PRIO = 1
) (
    input  logic      i_req,
    input  logic      d_req,
    input  arb_port_t rr_ptr,
    output logic      grant_valid,
    output arb_port_t grant_port
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_port  = PORT_I;
        if (i_req && d_req) begin
            // Ties go to the data port in priority mode, else to whoever rr points at
            grant_port = (DATA_PRIO != 0) ? PORT_D : rr_ptr;
        end else if (d_req) begin
            grant_port = PORT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/darkbus_arbiter.sv
// ============================================================================
// darkbus_arbiter : two-master (fetch / load-store) arbiter for one darkbus slave
// Revision        : 1.0
// ============================================================================
`default_nettype none

module darkbus_arbiter
    import darkbus_pkg::*;
#(
    parameter int AW        = DARKBUS_AW,
    parameter int DW        = DARKBUS_DW,
    parameter int TIMEOUT   = 15,
    parameter int DATA_PRIO = 1
) (
    input  logic          XCLK,
    input  logic          XRES,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          s_en,
    output logic          s_rw,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_valid
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

    arb_state_t    state;
    arb_port_t     owner;
    arb_port_t     rr_ptr;
    logic [TW-1:0] timer;
    logic          grant_valid;
    arb_port_t     grant_port;
    logic          timed_out;

    darkbus_arb_pick #(
        .DATA_PRIO (DATA_PRIO)
    ) u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    assign timed_out = !s_valid && (timer == TIMEOUT_T);

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state   <= IDLE;
            owner   <= PORT_I;
            rr_ptr  <= PORT_I;
            timer   <= '0;
            i_ack   <= 1'b0;
            i_rdata <= '0;
            i_err   <= 1'b0;
            d_ack   <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
            s_en    <= 1'b0;
            s_rw    <= 1'b0;
            s_addr  <= '0;
            s_wdata <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= grant_port;
                        rr_ptr <= other_port(grant_port);
                        s_en   <= 1'b1;
                        state  <= BUSY;
                        if (grant_port == PORT_D) begin
                            s_addr  <= d_addr;
                            s_rw    <= d_rw;
                            s_wdata <= d_wdata;
                        end else begin
                            s_addr  <= i_addr;
                            s_rw    <= 1'b0;
                            s_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    timer <= timer + 1'b1;
                    if (s_valid || timed_out) begin
                        s_en  <= 1'b0;
                        state <= DONE;
                        // A timed-out read returns zero rather than whatever is on s_rdata
                        if (owner == PORT_I) begin
                            i_ack   <= 1'b1;
                            i_err   <= timed_out;
                            i_rdata <= timed_out ? '0 : s_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            d_err <= timed_out;
                            if (!s_rw) begin
                                d_rdata <= timed_out ? '0 : s_rdata;
                            end
                        end
                    end
                end
                DONE: begin
                    timer <= '0;
                    state <= IDLE;
                end
                default: begin
                    timer <= '0;
                    s_en  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_darkbus_arbiter.sv
// ============================================================================
// tb_darkbus_arbiter : vector table + scoreboard bench, priority and rr instances
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_darkbus_arbiter;

    typedef struct {
        int          k;
        bit          pd;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          mute;
        int          lat;
    } vec_t;

    typedef struct {
        int          k;
        bit          pd;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    logic        XCLK = 1'b0;
    logic        XRES = 1'b0;
    logic        i_req   [2];
    logic [31:0] i_addr  [2];
    logic        i_ack   [2];
    logic [31:0] i_rdata [2];
    logic        i_err   [2];
    logic        d_req   [2];
    logic        d_rw    [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_wdata [2];
    logic        d_ack   [2];
    logic [31:0] d_rdata [2];
    logic        d_err   [2];
    logic        s_en    [2];
    logic        s_rw    [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic        mute    [2];

    int          cyc = 0;
    int          cmp_n = 0;
    int          fail_n = 0;
    exp_t        sb[$];
    logic [31:0] drd [2];
    vec_t        vecs [8];

    always #5 XCLK = ~XCLK;
    always @(posedge XCLK) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h8) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
    endfunction

    // Instance 0: data priority; instance 1: round-robin. Each has its own slave model.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic        sv_q;
        logic [31:0] srd;
        logic        sval;

        darkbus_arbiter #(
            .AW        (32),
            .DW        (32),
            .TIMEOUT   (15),
            .DATA_PRIO ((k == 0) ? 1 : 0)
        ) u_dut (
            .XCLK    (XCLK),
            .XRES    (XRES),
            .i_req   (i_req[k]),
            .i_addr  (i_addr[k]),
            .i_ack   (i_ack[k]),
            .i_rdata (i_rdata[k]),
            .i_err   (i_err[k]),
            .d_req   (d_req[k]),
            .d_rw    (d_rw[k]),
            .d_addr  (d_addr[k]),
            .d_wdata (d_wdata[k]),
            .d_ack   (d_ack[k]),
            .d_rdata (d_rdata[k]),
            .d_err   (d_err[k]),
            .s_en    (s_en[k]),
            .s_rw    (s_rw[k]),
            .s_addr  (s_addr[k]),
            .s_wdata (s_wdata[k]),
            .s_rdata (srd),
            .s_valid (sval)
        );

        always_ff @(posedge XCLK or negedge XRES) begin
            if (!XRES) begin
                sv_q <= 1'b0;
                srd  <= '0;
            end else begin
                sv_q <= s_en[k];
                srd  <= rom(s_addr[k]);
            end
        end

        assign sval = sv_q & ~mute[k];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            fail_n++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input bit pd, input bit rw, input logic [31:0] addr,
                            input bit tmo, input int at);
        exp_t e;
        e.k   = k;
        e.pd  = pd;
        e.err = tmo;
        e.cyc = at;
        if (pd && rw) e.rdata = drd[k];
        else          e.rdata = tmo ? 32'h0 : rom(addr);
        if (pd && !rw) drd[k] = e.rdata;
        sb.push_back(e);
    endtask

    task automatic chk_reset(input int k);
        chk("rst_s_en",    s_en[k],    0);
        chk("rst_s_rw",    s_rw[k],    0);
        chk("rst_s_addr",  s_addr[k],  0);
        chk("rst_s_wdata", s_wdata[k], 0);
        chk("rst_acks",    {i_ack[k], d_ack[k]}, 0);
        chk("rst_errs",    {i_err[k], d_err[k]}, 0);
        chk("rst_i_rdata", i_rdata[k], 0);
        chk("rst_d_rdata", d_rdata[k], 0);
    endtask

    always @(negedge XCLK) begin
        for (int k = 0; k < 2; k++) begin
            if (i_ack[k] && d_ack[k]) chk("dual_ack", 1, 0);
            if (i_ack[k] || d_ack[k]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {i_ack[k], d_ack[k]}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_inst",  k, e.k);
                    chk("ack_port",  d_ack[k], e.pd);
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_rdata", e.pd ? d_rdata[k] : i_rdata[k], e.rdata);
                    chk("ack_err",   e.pd ? d_err[k] : i_err[k], e.err);
                    chk("ack_s_en",  s_en[k], 0);
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge XCLK); #1;
            n++;
        end
        chk("ack_wait_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int c0;
        @(negedge XCLK);
        mute[v.k] = v.mute;
        if (v.pd) begin
            d_req[v.k]   = 1'b1;
            d_rw[v.k]    = v.rw;
            d_addr[v.k]  = v.addr;
            d_wdata[v.k] = v.wdata;
            i_addr[v.k]  = 32'hFFFF_FFF0;
        end else begin
            i_req[v.k]   = 1'b1;
            i_addr[v.k]  = v.addr;
            d_rw[v.k]    = 1'b1;
            d_wdata[v.k] = 32'hFFFF_FFFF;
        end
        c0 = cyc;
        push_exp(v.k, v.pd, v.rw, v.addr, v.mute, c0 + v.lat);
        @(negedge XCLK); #1;
        chk("c1_s_en",    s_en[v.k],    1);
        chk("c1_s_addr",  s_addr[v.k],  v.addr);
        chk("c1_s_rw",    s_rw[v.k],    v.pd & v.rw);
        chk("c1_s_wdata", s_wdata[v.k], v.pd ? v.wdata : 32'h0);
        wait_drain(40);
        i_req[v.k] = 1'b0;
        d_req[v.k] = 1'b0;
        mute[v.k]  = 1'b0;
    endtask

    initial begin
        int c0;
        for (int k = 0; k < 2; k++) begin
            i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_rw[k] = 0;
            d_addr[k] = 0; d_wdata[k] = 0; mute[k] = 0; drd[k] = 0;
        end
        vecs[0] = '{0, 1'b0, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 3};
        vecs[1] = '{0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[2] = '{0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 3};
        vecs[3] = '{0, 1'b1, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0, 3};
        vecs[4] = '{0, 1'b1, 1'b0, 32'h0000_0300, 32'h0,         1'b1, 17};
        vecs[5] = '{0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,         1'b1, 17};
        vecs[6] = '{1, 1'b0, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 3};
        vecs[7] = '{1, 1'b1, 1'b0, 32'h0000_0003, 32'h0,         1'b0, 3};

        repeat (2) @(negedge XCLK);
        chk_reset(0);
        chk_reset(1);
        XRES = 1'b1;
        @(negedge XCLK);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Priority instance, simultaneous requests: data first, fetch after.
        @(negedge XCLK);
        i_req[0] = 1; i_addr[0] = 32'h10;
        d_req[0] = 1; d_rw[0] = 0; d_addr[0] = 32'h20;
        c0 = cyc;
        push_exp(0, 1'b1, 1'b0, 32'h20, 1'b0, c0 + 3);
        push_exp(0, 1'b0, 1'b0, 32'h10, 1'b0, c0 + 7);
        for (int t = 1; t <= 8; t++) begin
            @(negedge XCLK); #1;
            if (t == 1) chk("prio_first_addr", s_addr[0], 32'h20);
            if (t == 5) chk("prio_second_addr", {s_en[0], s_addr[0]}, {1'b1, 32'h10});
            if (d_ack[0]) d_req[0] = 0;
            if (i_ack[0]) i_req[0] = 0;
        end
        wait_drain(4);

        // Round-robin instance, both requests held: I,D,I,D.
        @(negedge XCLK);
        i_req[1] = 1; i_addr[1] = 32'h40;
        d_req[1] = 1; d_rw[1] = 0; d_addr[1] = 32'h80;
        c0 = cyc;
        push_exp(1, 1'b0, 1'b0, 32'h40, 1'b0, c0 + 3);
        push_exp(1, 1'b1, 1'b0, 32'h80, 1'b0, c0 + 7);
        push_exp(1, 1'b0, 1'b0, 32'h40, 1'b0, c0 + 11);
        push_exp(1, 1'b1, 1'b0, 32'h80, 1'b0, c0 + 15);
        for (int t = 1; t <= 16; t++) begin
            @(negedge XCLK); #1;
            if (t == 1) chk("rr_first_addr", s_addr[1], 32'h40);
            if (t == 5) chk("rr_second_addr", s_addr[1], 32'h80);
            if (t == 15) begin i_req[1] = 0; d_req[1] = 0; end
        end
        wait_drain(4);

        // Reset in the middle of a fetch: abandoned, then fresh arbitration.
        @(negedge XCLK);
        i_req[1] = 1; i_addr[1] = 32'h08;
        @(negedge XCLK);
        @(negedge XCLK); #1;
        XRES = 1'b0;
        #1;
        chk("rst_async_s_en", s_en[1], 0);
        i_req[1] = 0;
        drd[0] = 0;
        drd[1] = 0;
        repeat (2) @(negedge XCLK);
        chk_reset(1);
        chk_reset(0);
        XRES = 1'b1;
        @(negedge XCLK);
        i_req[1] = 1; i_addr[1] = 32'h14;
        d_req[1] = 1; d_rw[1] = 0; d_addr[1] = 32'h18;
        c0 = cyc;
        push_exp(1, 1'b0, 1'b0, 32'h14, 1'b0, c0 + 3);
        push_exp(1, 1'b1, 1'b0, 32'h18, 1'b0, c0 + 7);
        for (int t = 1; t <= 9; t++) begin
            @(negedge XCLK); #1;
            if (t == 1) chk("post_rst_first_addr", s_addr[1], 32'h14);
            if (i_ack[1]) i_req[1] = 0;
            if (d_ack[1]) d_req[1] = 0;
        end
        wait_drain(4);

        repeat (6) @(negedge XCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule

`default_nettype wire
